// File: rtl/cv32e40x_wb_stage.sv
// Writeback stage: single-entry holding slot for an EX instruction, load response
// buffering under halt, and kill/drain handling. Optional macro CV32E40X_WB_LOAD_EXTEND_EN.
module cv32e40x_wb_stage #(
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_valid_i,
  input  logic                     ex_rf_we_i,
  input  logic [RF_ADDR_WIDTH-1:0] ex_rf_waddr_i,
  input  logic [31:0]              ex_rf_wdata_i,
  input  logic                     ex_load_i,
  input  logic [1:0]               ex_load_size_i,
  input  logic                     ex_load_signed_i,
  input  logic [1:0]               ex_addr_lsb_i,
  output logic                     wb_ready_o,
  input  logic                     lsu_rvalid_i,
  input  logic [31:0]              lsu_rdata_i,
  input  logic                     lsu_err_i,
  input  logic                     halt_wb_i,
  input  logic                     kill_wb_i,
  output logic                     rf_we_o,
  output logic [RF_ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [31:0]              rf_wdata_o,
  output logic                     wb_valid_o,
  output logic                     wb_err_o
);

  typedef enum logic [2:0] {EMPTY, BUSY, LOAD_WAIT, LOAD_HELD, DRAIN} state_e;

  state_e                   state_q, state_d;
  logic                     rf_we_q, rf_we_d;
  logic [RF_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [31:0]              rf_wdata_q, rf_wdata_d;
  logic                     load_q, load_d;
  logic [1:0]               load_size_q, load_size_d;
  logic                     load_signed_q, load_signed_d;
  logic [1:0]               addr_lsb_q, addr_lsb_d;
  logic [31:0]              buf_rdata_q, buf_rdata_d;
  logic                     buf_err_q, buf_err_d;

  logic        done, retire, accept;
  logic [31:0] ld_raw, ld_data;
  logic        ld_err;

  // A buffered response (LOAD_HELD) takes the place of the live LSU response.
  assign ld_raw = (state_q == LOAD_HELD) ? buf_rdata_q : lsu_rdata_i;
  assign ld_err = (state_q == LOAD_HELD) ? buf_err_q   : lsu_err_i;

`ifdef CV32E40X_WB_LOAD_EXTEND_EN
  logic [31:0] ld_shift;
  always_comb begin
    ld_shift = ld_raw >> {addr_lsb_q, 3'b000};
    case (load_size_q)
      2'b00:   ld_data = {{24{load_signed_q & ld_shift[7]}},  ld_shift[7:0]};
      2'b01:   ld_data = {{16{load_signed_q & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end
`else
  // Alignment is done in the LSU; the size/sign/lsb fields are not needed here.
  logic unused_ext;
  assign unused_ext = ^{load_size_q, load_signed_q, addr_lsb_q};
  assign ld_data    = ld_raw;
`endif

  always_comb begin
    done   = (state_q == BUSY) || (state_q == LOAD_HELD) ||
             ((state_q == LOAD_WAIT) && lsu_rvalid_i);
    retire = done && !halt_wb_i && !kill_wb_i;
    wb_ready_o = (state_q == EMPTY) || retire;
    accept     = ex_valid_i && wb_ready_o;
    wb_valid_o = retire;
    wb_err_o   = retire && load_q && ld_err;
    rf_we_o    = retire && rf_we_q && !(load_q && ld_err);
    rf_waddr_o = rf_waddr_q;
    rf_wdata_o = load_q ? ld_data : rf_wdata_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUSY, LOAD_HELD: begin
        if (kill_wb_i || retire) state_d = EMPTY;
      end
      LOAD_WAIT: begin
        if (kill_wb_i)         state_d = lsu_rvalid_i ? EMPTY : DRAIN;
        else if (retire)       state_d = EMPTY;
        else if (lsu_rvalid_i) state_d = LOAD_HELD;
      end
      DRAIN: begin
        if (lsu_rvalid_i) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (accept) state_d = ex_load_i ? LOAD_WAIT : BUSY;
  end

  always_comb begin
    rf_we_d       = rf_we_q;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    load_d        = load_q;
    load_size_d   = load_size_q;
    load_signed_d = load_signed_q;
    addr_lsb_d    = addr_lsb_q;
    buf_rdata_d   = buf_rdata_q;
    buf_err_d     = buf_err_q;
    if (accept) begin
      rf_we_d       = ex_rf_we_i;
      rf_waddr_d    = ex_rf_waddr_i;
      rf_wdata_d    = ex_rf_wdata_i;
      load_d        = ex_load_i;
      load_size_d   = ex_load_size_i;
      load_signed_d = ex_load_signed_i;
      addr_lsb_d    = ex_addr_lsb_i;
    end
    if ((state_q == LOAD_WAIT) && lsu_rvalid_i && halt_wb_i && !kill_wb_i) begin
      buf_rdata_d = lsu_rdata_i;
      buf_err_d   = lsu_err_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= EMPTY;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      load_q        <= 1'b0;
      load_size_q   <= '0;
      load_signed_q <= 1'b0;
      addr_lsb_q    <= '0;
      buf_rdata_q   <= '0;
      buf_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      load_q        <= load_d;
      load_size_q   <= load_size_d;
      load_signed_q <= load_signed_d;
      addr_lsb_q    <= addr_lsb_d;
      buf_rdata_q   <= buf_rdata_d;
      buf_err_q     <= buf_err_d;
    end
  end

  // A response in BUSY is a protocol error. EMPTY is tolerated: a reset can
  // orphan an outstanding load whose response still arrives afterwards.
  a_no_rvalid_busy: assert property (@(posedge clk) disable iff (rst)
    !(lsu_rvalid_i && (state_q == BUSY)));

endmodule

// File: tb/tb_cv32e40x_wb_stage.sv
// Bench for cv32e40x_wb_stage: directed scenarios plus random traffic, all
// checked cycle by cycle against a slot-level behavioural model.
module tb_cv32e40x_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, ex_rf_we_i, ex_load_i, ex_load_signed_i;
  logic [4:0]  ex_rf_waddr_i;
  logic [31:0] ex_rf_wdata_i, lsu_rdata_i;
  logic [1:0]  ex_load_size_i, ex_addr_lsb_i;
  logic        wb_ready_o, lsu_rvalid_i, lsu_err_i, halt_wb_i, kill_wb_i;
  logic        rf_we_o, wb_valid_o, wb_err_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  int total = 0;
  int bad   = 0;

  cv32e40x_wb_stage #(.RF_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_rf_we_i(ex_rf_we_i), .ex_rf_waddr_i(ex_rf_waddr_i),
    .ex_rf_wdata_i(ex_rf_wdata_i), .ex_load_i(ex_load_i), .ex_load_size_i(ex_load_size_i),
    .ex_load_signed_i(ex_load_signed_i), .ex_addr_lsb_i(ex_addr_lsb_i),
    .wb_ready_o(wb_ready_o), .lsu_rvalid_i(lsu_rvalid_i), .lsu_rdata_i(lsu_rdata_i),
    .lsu_err_i(lsu_err_i), .halt_wb_i(halt_wb_i), .kill_wb_i(kill_wb_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .wb_valid_o(wb_valid_o), .wb_err_o(wb_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: one instruction slot, whether its load response has been seen,
  // and whether a killed load is still owed a response.
  bit          m_occ, m_ld, m_got, m_drain, m_we, m_sg, m_ebuf;
  logic [4:0]  m_wa;
  logic [31:0] m_wd, m_rbuf;
  logic [1:0]  m_sz, m_lsb;

  function automatic logic [31:0] m_ext(logic [31:0] d, logic [1:0] sz, bit sg, logic [1:0] lsb);
`ifdef CV32E40X_WB_LOAD_EXTEND_EN
    longint s, v;
    s = longint'(d) / (longint'(1) << (8 * lsb));
    if (sz == 0)      begin v = s % 256;   if (sg && v >= 128)   v -= 256;   end
    else if (sz == 1) begin v = s % 65536; if (sg && v >= 32768) v -= 65536; end
    else v = s;
    return v[31:0];
`else
    return d;
`endif
  endfunction

  task automatic m_reset();
    m_occ = 0; m_ld = 0; m_got = 0; m_drain = 0; m_we = 0; m_sg = 0; m_ebuf = 0;
    m_wa = 0; m_wd = 0; m_rbuf = 0; m_sz = 0; m_lsb = 0;
  endtask

  // Drive one cycle of inputs, check outputs against the model, advance the model.
  task automatic cyc(input bit ev, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input bit ld, input logic [1:0] sz, input bit sg, input logic [1:0] lsb,
                     input bit rv, input logic [31:0] rd, input bit er, input bit hl, input bit kl);
    bit done, ret, rdy, err;
    logic [31:0] data;
    @(negedge clk);
    ex_valid_i = ev; ex_rf_we_i = we; ex_rf_waddr_i = wa; ex_rf_wdata_i = wd;
    ex_load_i = ld; ex_load_size_i = sz; ex_load_signed_i = sg; ex_addr_lsb_i = lsb;
    lsu_rvalid_i = rv; lsu_rdata_i = rd; lsu_err_i = er; halt_wb_i = hl; kill_wb_i = kl;
    #1;
    done = m_occ && (!m_ld || m_got || rv);
    ret  = done && !hl && !kl;
    rdy  = (!m_occ && !m_drain) || ret;
    err  = m_ld && (m_got ? m_ebuf : er);
    data = m_ld ? m_ext(m_got ? m_rbuf : rd, m_sz, m_sg, m_lsb) : m_wd;
    chk("wb_valid", wb_valid_o, ret);
    chk("wb_err",   wb_err_o,   ret && err);
    chk("rf_we",    rf_we_o,    ret && m_we && !err);
    chk("ready",    wb_ready_o, rdy);
    if (ret && m_we && !err) begin
      chk("waddr", rf_waddr_o, m_wa);
      chk("wdata", rf_wdata_o, data);
    end
    if (m_drain) begin
      if (rv) m_drain = 0;
    end else if (m_occ) begin
      if (kl) begin
        m_occ = 0;
        if (m_ld && !m_got && !rv) m_drain = 1;
      end else if (ret) begin
        m_occ = 0;
      end else if (m_ld && !m_got && rv) begin
        m_got = 1; m_rbuf = rd; m_ebuf = er;
      end
    end
    if (ev && rdy) begin
      m_occ = 1; m_got = 0; m_we = we; m_wa = wa; m_wd = wd;
      m_ld = ld; m_sz = sz; m_sg = sg; m_lsb = lsb;
    end
  endtask

  task automatic idle(input bit hl = 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, hl, 0);
  endtask

  task automatic respond(input logic [31:0] rd, input bit er = 0, input bit hl = 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, rd, er, hl, 0);
  endtask

  task automatic issue_load(input logic [4:0] wa, input logic [1:0] sz, input bit sg, input logic [1:0] lsb);
    cyc(1, 1, wa, 32'hDEAD_BEEF, 1, sz, sg, lsb, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    ex_valid_i = 0; lsu_rvalid_i = 0; halt_wb_i = 0; kill_wb_i = 0; lsu_err_i = 0;
    m_reset();
    #1;
    chk("rst_ready", wb_ready_o, 1);
    chk("rst_we",    rf_we_o,    0);
    chk("rst_valid", wb_valid_o, 0);
    chk("rst_err",   wb_err_o,   0);
    chk("rst_waddr", rf_waddr_o, 0);
    chk("rst_wdata", rf_wdata_o, 0);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1;
    ex_valid_i = 0; ex_rf_we_i = 0; ex_rf_waddr_i = 0; ex_rf_wdata_i = 0;
    ex_load_i = 0; ex_load_size_i = 0; ex_load_signed_i = 0; ex_addr_lsb_i = 0;
    lsu_rvalid_i = 0; lsu_rdata_i = 0; lsu_err_i = 0; halt_wb_i = 0; kill_wb_i = 0;
    m_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Back-to-back non-loads
    cyc(1, 1, 5, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 6, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("b2b_x5", {rf_we_o, 26'd0, rf_waddr_o, rf_wdata_o[7:0]} , {1'b1, 26'd0, 5'd5, 8'h11});
    idle();
    chk("b2b_x6", {rf_we_o, 26'd0, rf_waddr_o, rf_wdata_o[7:0]}, {1'b1, 26'd0, 5'd6, 8'h22});

    // Signed byte load at lsb 2
    issue_load(7, 2'b00, 1, 2'd2);
    respond(32'h0080_FF00);
`ifdef CV32E40X_WB_LOAD_EXTEND_EN
    chk("lb_ext", rf_wdata_o, 32'hFFFF_FF80);
`else
    chk("lb_raw", rf_wdata_o, 32'h0080_FF00);
`endif

    // Response arrives while halted, retired once released
    issue_load(8, 2'b10, 0, 0);
    respond(32'hCAFE_0000, 0, 1);
    idle(1);
    chk("held_ready", wb_ready_o, 0);
    idle(1);
    idle(0);
    chk("held_data", rf_wdata_o, 32'hCAFE_0000);
    chk("held_we", rf_we_o, 1);

    // Kill before response -> drain
    issue_load(9, 2'b10, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle();
    chk("drain_ready", wb_ready_o, 0);
    idle();
    respond(32'h1234_5678);
    chk("drain_we", rf_we_o, 0);
    chk("drain_valid", wb_valid_o, 0);
    idle();

    // Load bus error
    issue_load(10, 2'b10, 0, 0);
    respond(32'h5555_5555, 1);
    chk("err_flag", {wb_valid_o, wb_err_o, rf_we_o}, 3'b110);

    // Reset while a load is outstanding; late response must not write
    issue_load(11, 2'b10, 0, 0);
    idle();
    do_reset();
    respond(32'h7777_7777);
    chk("late_we", rf_we_o, 0);
    idle();

    // Random traffic under the protocol: responses only when one is owed
    for (int i = 0; i < 600; i++) begin
      bit owed, rv;
      owed = (m_occ && m_ld && !m_got) || m_drain;
      rv   = owed && ($urandom_range(0, 9) < 4);
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 1), 5'($urandom), $urandom,
          $urandom_range(0, 1), 2'($urandom_range(0, 2)), $urandom_range(0, 1),
          2'($urandom_range(0, 3)), rv, $urandom, $urandom_range(0, 9) < 2,
          $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
